// File: rtl/led_csr_pkg.sv
// Shared definitions for the LED CSR agent: register addresses, LED modes
// and the toggle-gap FSM states.
package led_csr_pkg;

  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_TOGGLE  = 3'd1;
  localparam logic [2:0] ADDR_STATUS  = 3'd2;
  localparam logic [2:0] ADDR_WCOUNT  = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH = 3'd4;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ON     = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_TOGGLE = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } state_e;

endpackage

// File: rtl/led_csr_rdpipe.sv
// Fixed-latency read return pipe: valid and data delayed by DEPTH cycles.
// Data is forced to zero in any slot that does not carry a valid read.
module led_csr_rdpipe #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [W-1:0]     dat_q [DEPTH];
  logic [W-1:0]     dat_d [DEPTH];

  // NOTE: every signal assigned here is written on every path, so no latch is inferred.
  always_comb begin
    vld_d[0] = in_valid;
    dat_d[0] = in_valid ? in_data : '0;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // NOTE: the data slots are reset too, so readdata is zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage shifts from pre-edge values.
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/led_csr_agent.sv
// Avalon-MM CSR agent driving the LED blink controller (mode + toggle strobe).
// Define LED_CSR_IRQ_EN to build the led_state change interrupt.
module led_csr_agent
  import led_csr_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int PULSE_GAP    = 8,
  parameter int CNT_W        = 16
) (
  input  logic        clock_sink_clk,
  input  logic        reset_sink_reset,
  input  logic [2:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  input  logic        led_state,
  output logic [1:0]  blink_flag,
  output logic        csr_write,
  output logic        irq
);

  state_e           state_q;
  logic [7:0]       gap_cnt_q;
  logic             csr_write_q;
  mode_e            mode_q, mode_d;
  logic [31:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0] wcount_q, wcount_d;
  logic [31:0]      rd_data;
  logic             gap_busy, wr_acc, rd_acc, toggle_acc, irq_pend;

  // Only a TOGGLE write during the gap stalls; everything else passes.
  assign gap_busy        = (state_q == ST_GAP);
  assign avs_waitrequest = gap_busy && avs_write && (avs_address == ADDR_TOGGLE);
  assign wr_acc          = avs_write && !avs_waitrequest;
  assign rd_acc          = avs_read && !avs_write && !avs_waitrequest;
  assign toggle_acc      = wr_acc && (avs_address == ADDR_TOGGLE);

`ifdef LED_CSR_IRQ_EN
  // sync_q[1:0] synchronise led_state, sync_q[2] holds the previous level.
  logic [2:0] sync_q, sync_d;
  logic       irq_pend_q, irq_pend_d;

  always_comb begin
    sync_d     = {sync_q[1:0], led_state};
    irq_pend_d = irq_pend_q;
    if (wr_acc && (avs_address == ADDR_STATUS) && avs_writedata[2]) irq_pend_d = 1'b0;
    if (sync_q[2] ^ sync_q[1]) irq_pend_d = 1'b1;
  end

  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      sync_q     <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      irq_pend_q <= irq_pend_d;
    end
  end

  assign irq_pend = irq_pend_q;
`else
  assign irq_pend = 1'b0;
`endif

  assign irq = irq_pend;

  always_comb begin
    mode_d    = mode_q;
    scratch_d = scratch_q;
    wcount_d  = wcount_q;
    if (wr_acc) begin
      if (avs_address == ADDR_CTRL)    mode_d    = mode_e'(avs_writedata[1:0]);
      if (avs_address == ADDR_SCRATCH) scratch_d = avs_writedata;
      if (avs_address <= ADDR_SCRATCH) wcount_d  = wcount_q + CNT_W'(1);
    end
  end

  always_comb begin
    rd_data = '0;
    case (avs_address)
      ADDR_CTRL:    rd_data = {30'd0, mode_q};
      ADDR_STATUS:  rd_data = {26'd0, mode_q, 1'b0, irq_pend, gap_busy, led_state};
      ADDR_WCOUNT:  rd_data = 32'(wcount_q);
      ADDR_SCRATCH: rd_data = scratch_q;
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      mode_q    <= MODE_OFF;
      scratch_q <= '0;
      wcount_q  <= '0;
    end else begin
      mode_q    <= mode_d;
      scratch_q <= scratch_d;
      wcount_q  <= wcount_d;
    end
  end

  // Leaving GAP as the counter reaches zero spaces pulses PULSE_GAP+1 apart.
  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      csr_write_q <= 1'b0;
    end else begin
      csr_write_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (toggle_acc) begin
            csr_write_q <= 1'b1;
            gap_cnt_q   <= 8'(PULSE_GAP);
            state_q     <= ST_GAP;
          end
        end
        ST_GAP: begin
          gap_cnt_q <= gap_cnt_q - 8'd1;
          if (gap_cnt_q == 8'd1) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign csr_write  = csr_write_q;
  assign blink_flag = mode_q;

  led_csr_rdpipe #(
    .DEPTH (READ_LATENCY),
    .W     (32)
  ) u_rdpipe (
    .clk       (clock_sink_clk),
    .rst       (reset_sink_reset),
    .in_valid  (rd_acc),
    .in_data   (rd_data),
    .out_valid (avs_readdatavalid),
    .out_data  (avs_readdata)
  );

endmodule

// File: doc/led_csr_agent.md
Name: led_csr_agent

Overview:
- Avalon-MM agent that drives the LED blink controller's control inputs: `blink_flag` (mode) and `csr_write` (toggle strobe).
- Sits between the HPS/JTAG bridge and the LED controller. It decodes register writes into mode settings and one-cycle toggle pulses, and provides readback and an access counter.
- Also enforces a minimum gap between toggle pulses by back-pressuring the bus with `waitrequest`.

Parameters:
- `READ_LATENCY`, 2, cycles from read acceptance to `avs_readdatavalid`; legal 1..4.
- `PULSE_GAP`, 8, minimum cycles from one `csr_write` pulse to the next; legal 1..255.
- `CNT_W`, 16, width of the write-count register.

Ports:
- `clock_sink_clk`  in  1  single clock for the whole block.
- `reset_sink_reset`  in  1  asynchronous, active-high reset.
- `avs_address`  in  3  word address.
- `avs_write`  in  1  write request.
- `avs_writedata`  in  32  write data.
- `avs_read`  in  1  read request.
- `avs_readdata`  out  32  read data.
- `avs_readdatavalid`  out  1  read data valid strobe.
- `avs_waitrequest`  out  1  agent stall.
- `led_state`  in  1  current LED level, fed back from the controller output.
- `blink_flag`  out  2  mode to the controller: 00 off, 01 on, 10 blink, 11 CSR toggle.
- `csr_write`  out  1  one-cycle toggle strobe.
- `irq`  out  1  interrupt (Optional Feature).

Behaviour:
- Reset values: `blink_flag`=00, `csr_write`=0, `avs_readdata`=0, `avs_readdatavalid`=0, `avs_waitrequest`=0, `irq`=0. The count register, scratch register, gap counter and read pipe are all cleared.
- Register map:
  - 0 CTRL: RW, bits[1:0]=mode.
  - 1 TOGGLE: WO, reads 0.
  - 2 STATUS: RO. bit0=`led_state`, bit1=gap busy, bit2=irq pending, bits[5:4]=mode.
  - 3 WCOUNT: RO, zero-extended.
  - 4 SCRATCH: RW, 32 bit.
  - 5..7: reads 0, writes ignored.
- Access acceptance:
  - A transfer is accepted on a rising edge where (`avs_read` or `avs_write`) is high and `avs_waitrequest` is low.
  - `avs_read` and `avs_write` both high in the same cycle: the write takes effect and the read is dropped (no `avs_readdatavalid`).
- Writes take effect on the accept edge. `blink_flag` updates the cycle after the CTRL write is accepted.
- TOGGLE handling uses a two-state FSM:
  - IDLE: a TOGGLE write is accepted → `csr_write`=1 for exactly the next cycle, gap counter loaded with `PULSE_GAP`, go to GAP.
  - GAP: counter decrements each cycle; at 0 → IDLE.
  - While in GAP, `avs_waitrequest` is high combinationally whenever `avs_write`=1 and `avs_address`=1. Requests to any other address are never stalled.
  - Back-to-back TOGGLE writes therefore produce pulses exactly `PULSE_GAP`+1 cycles apart.
- TOGGLE writes are accepted in any mode. `csr_write` pulses even when mode≠11; the controller ignores it in that case.
- WCOUNT: increments by 1 on every accepted write to addresses 0..4. It wraps from 2^`CNT_W`−1 to 0.
- Reads:
  - Data is sampled at the accept edge and delivered through a `READ_LATENCY`-deep pipe.
  - `avs_readdatavalid` pulses one cycle per accepted read. Reads are fully pipelined, one per cycle.
  - `avs_readdata` returns 0 whenever `avs_readdatavalid` is low.
- Reset mid-operation returns every state to its reset value. In-flight reads are discarded (no late valid), and any pending gap is cleared.

Optional Feature:
- Macro: `LED_CSR_IRQ_EN`.
- Enabled:
  - Any change of synchronised `led_state` (2-flop synchroniser) sets an irq-pending bit.
  - `irq` equals the pending bit, registered.
  - Writing STATUS with bit2=1 clears it. If a set and a clear coincide, the set wins.
- Disabled:
  - No synchroniser or pending bit is built.
  - `irq` is tied to 0 and STATUS bit2 reads 0.

Decomposition:
- Package `led_csr_pkg` holds:
  - address constants `ADDR_CTRL`, `ADDR_TOGGLE`, `ADDR_STATUS`, `ADDR_WCOUNT`, `ADDR_SCRATCH`;
  - mode enum `MODE_OFF`/`MODE_ON`/`MODE_BLINK`/`MODE_TOGGLE`;
  - FSM state enum `ST_IDLE`/`ST_GAP`.
- One sub-module: `led_csr_rdpipe`, a parameterised valid+data delay line of depth `READ_LATENCY`.

Test Plan:
- Reset, then write CTRL=2 → `blink_flag`=10 on the next cycle. Read CTRL → `avs_readdatavalid` exactly 2 cycles after accept, data 0x2.
- Two back-to-back TOGGLE writes with `PULSE_GAP`=8 → first `csr_write` pulse 1 cycle after accept. `avs_waitrequest` is high during the gap, and the second pulse comes exactly 9 cycles after the first. Each pulse is 1 cycle wide.
- During GAP, write SCRATCH=0xDEADBEEF and read STATUS → neither is stalled. Readback gives SCRATCH=0xDEADBEEF and STATUS bit1=1.
- With `CNT_W`=4, do 17 accepted writes → WCOUNT reads 1. Writes to address 6 do not count.
- Issue 3 consecutive reads, then assert reset at cycle 1 after the last accept → no `avs_readdatavalid` after reset. All outputs return to reset values.
- With `LED_CSR_IRQ_EN` defined, toggle `led_state` 0→1 → `irq`=1 within 4 cycles. Write STATUS=0x4 → `irq`=0. Without the macro, `irq` stays 0.
